// File: rtl/regroup_frag_write_pkg.sv
// Shared definitions for the regroup write stage: packet tag encodings,
// bufid width and the per-build buffer offset widths.
package regroup_frag_write_pkg;

  localparam int BUFID_W = 9;
  localparam int PKT_W   = 134;

  // Word tag carried in bits [133:132] of every packet word
  typedef logic [1:0] pkt_tag_t;
  localparam pkt_tag_t TAG_HEAD = 2'b01;
  localparam pkt_tag_t TAG_MID  = 2'b11;
  localparam pkt_tag_t TAG_TAIL = 2'b10;

  // Buffer offset width for the fragment and non-fragment builds
  localparam int OFFSET_W_FRAG    = 3;
  localparam int OFFSET_W_NOTFRAG = 7;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/regroup_frag_write_bufid_queue.sv
// Small show-ahead FIFO of completed bufids waiting for the packet reader.
// The caller guarantees no push when full and no pop when empty.
module regroup_bufid_queue
  import regroup_frag_write_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     push,
  input  logic [BUFID_W-1:0]       push_data,
  input  logic                     pop,
  output logic [BUFID_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [BUFID_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               pop_ok;

  assign pop_ok    = pop && (count_reg != '0);
  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;
  assign empty     = (count_reg == '0);

  // Storage is not reset; stale entries are never visible while count is 0
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      if (push && !pop_ok) begin
        count_reg <= count_reg + (PTR_W+1)'(1);
      end else if (pop_ok && !push) begin
        count_reg <= count_reg - (PTR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/regroup_frag_write.sv
// Packet write stage: allocates a bufid per packet, stores the words into
// packet RAM at {bufid, offset} and dispatches finished bufids to the reader.
module regroup_frag_write
  import regroup_frag_write_pkg::*;
#(
  parameter int OFFSET_W    = OFFSET_W_FRAG,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [PKT_W-1:0]              iv_pkt_data,
  input  logic                          i_pkt_data_wr,
  input  logic [BUFID_W-1:0]            iv_free_bufid,
  input  logic                          i_free_bufid_empty,
  output logic                          o_free_bufid_rd,
  output logic [PKT_W-1:0]              ov_pkt_ram_wdata,
  output logic                          o_pkt_ram_wr,
  output logic [BUFID_W+OFFSET_W-1:0]   ov_pkt_ram_waddr,
  output logic [BUFID_W-1:0]            ov_bufid,
  output logic                          o_bufid_wr,
  input  logic                          i_pkt_last_cycle_valid,
  output logic [15:0]                   ov_drop_cnt,
  output logic [15:0]                   ov_trunc_cnt
);

  localparam int ADDR_W = BUFID_W + OFFSET_W;
  localparam int CNT_W  = $clog2(QUEUE_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WRITE   = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]          state_reg, state_next;
  logic [OFFSET_W-1:0] offset_reg, offset_next;
  logic [BUFID_W-1:0]  bufid_reg, bufid_next;
  logic                free_rd_next;
  logic                ram_wr_next;
  logic [ADDR_W-1:0]   ram_waddr_next;
  logic [PKT_W-1:0]    ram_wdata_next;
  logic [15:0]         drop_cnt_next;
  logic [15:0]         trunc_cnt_next;

  logic                q_push;
  logic                q_pop;
  logic [BUFID_W-1:0]  q_head;
  logic [CNT_W-1:0]    q_count;
  logic                q_empty;
  logic                reader_busy_reg;
  logic                dispatch;

  pkt_tag_t pkt_tag;
  assign pkt_tag = iv_pkt_data[PKT_W-1 -: 2];

  always_comb begin
    state_next     = state_reg;
    offset_next    = offset_reg;
    bufid_next     = bufid_reg;
    free_rd_next   = 1'b0;
    ram_wr_next    = 1'b0;
    ram_waddr_next = '0;
    ram_wdata_next = '0;
    drop_cnt_next  = ov_drop_cnt;
    trunc_cnt_next = ov_trunc_cnt;
    q_push         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_pkt_data_wr && (pkt_tag == TAG_HEAD)) begin
          // Admitting only with a free queue slot means the later push always fits
          if (!i_free_bufid_empty && (q_count < CNT_W'(QUEUE_DEPTH))) begin
            free_rd_next   = 1'b1;
            bufid_next     = iv_free_bufid;
            ram_wr_next    = 1'b1;
            ram_waddr_next = {iv_free_bufid, {OFFSET_W{1'b0}}};
            ram_wdata_next = iv_pkt_data;
            offset_next    = OFFSET_W'(1);
            state_next     = ST_WRITE;
          end else begin
            drop_cnt_next  = sat_inc16(ov_drop_cnt);
            state_next     = ST_DISCARD;
          end
        end
      end

      ST_WRITE: begin
        if (i_pkt_data_wr) begin
          ram_wr_next    = 1'b1;
          ram_waddr_next = {bufid_reg, offset_reg};
          if (pkt_tag == TAG_TAIL) begin
            ram_wdata_next = iv_pkt_data;
            q_push         = 1'b1;
            state_next     = ST_IDLE;
          end else if (offset_reg == {OFFSET_W{1'b1}}) begin
            // Buffer full: close the stored packet with a synthetic tail
            ram_wdata_next = {TAG_TAIL, iv_pkt_data[PKT_W-3:0]};
            trunc_cnt_next = sat_inc16(ov_trunc_cnt);
            q_push         = 1'b1;
            state_next     = ST_DISCARD;
          end else begin
            ram_wdata_next = iv_pkt_data;
            offset_next    = offset_reg + OFFSET_W'(1);
          end
        end
      end

      ST_DISCARD: begin
        if (i_pkt_data_wr && (pkt_tag == TAG_TAIL)) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg        <= ST_IDLE;
      offset_reg       <= '0;
      bufid_reg        <= '0;
      o_free_bufid_rd  <= 1'b0;
      o_pkt_ram_wr     <= 1'b0;
      ov_pkt_ram_waddr <= '0;
      ov_pkt_ram_wdata <= '0;
      ov_drop_cnt      <= '0;
      ov_trunc_cnt     <= '0;
    end else begin
      state_reg        <= state_next;
      offset_reg       <= offset_next;
      bufid_reg        <= bufid_next;
      o_free_bufid_rd  <= free_rd_next;
      o_pkt_ram_wr     <= ram_wr_next;
      ov_pkt_ram_waddr <= ram_waddr_next;
      ov_pkt_ram_wdata <= ram_wdata_next;
      ov_drop_cnt      <= drop_cnt_next;
      ov_trunc_cnt     <= trunc_cnt_next;
    end
  end

  regroup_bufid_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_bufid_queue (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (q_push),
    .push_data (bufid_reg),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  // One packet in flight at the reader; its last-cycle pulse frees the slot
  assign dispatch = !reader_busy_reg && !q_empty;
  assign q_pop    = dispatch;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      reader_busy_reg <= 1'b0;
      o_bufid_wr      <= 1'b0;
      ov_bufid        <= '0;
    end else begin
      o_bufid_wr <= dispatch;
      if (dispatch) begin
        ov_bufid        <= q_head;
        reader_busy_reg <= 1'b1;
      end else if (i_pkt_last_cycle_valid) begin
        reader_busy_reg <= 1'b0;
      end
    end
  end

endmodule
